fetch_unit: RTL and testbench

- Instruction-fetch stage; consumes the execute stage's redirect outputs (bSel, aluOut) and produces the fetch→decode pipeline register.
- Owns the PC and issues requests to instruction memory, one outstanding request at a time.
- Handles variable-latency responses, hazard-unit stalls and branch/jump flushes.
- Sustains 1 instr/cycle with a zero-wait memory (imReady=1, response next cycle).

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    KILL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: sync reset to RESET_PC, redirect load, +4 increment; always word-aligned.
module pc_reg #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            incr,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else if (load) begin
      pc <= target & ALIGN_MASK;
    end else if (incr) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, stall hold buffer,
// redirect kill of in-flight responses, and the fetch->decode register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bSel,
  input  logic [XLEN-1:0] aluOut,
  input  logic            stall,
  output logic            imReq,
  output logic [XLEN-1:0] imAddr,
  input  logic            imReady,
  input  logic            imRValid,
  input  logic [XLEN-1:0] imRData,
  output logic [XLEN-1:0] insIF,
  output logic [XLEN-1:0] pcIF,
  output logic            validIF
);

  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSN);

  state_t          state, next_state;
  logic [XLEN-1:0] pc, fpc, h_ins, h_pc;
  logic            accept, deliver_rsp, deliver_hold, hold_load;

  pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (bSel),
    .incr   (accept),
    .target (aluOut),
    .pc     (pc)
  );

  assign imAddr = pc & ~XLEN'(3);
  assign accept = imReq & imReady;

  // Next-state and request logic; redirect outranks stall and responses.
  always_comb begin
    next_state   = state;
    imReq        = 1'b0;
    deliver_rsp  = 1'b0;
    deliver_hold = 1'b0;
    hold_load    = 1'b0;
    if (bSel) begin
      case (state)
        WAIT:    next_state = imRValid ? FETCH : KILL;
        KILL:    next_state = imRValid ? FETCH : KILL;
        default: next_state = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          imReq = 1'b1;
          if (imReady) next_state = WAIT;
        end
        WAIT: begin
          if (imRValid) begin
            if (stall) begin
              hold_load  = 1'b1;
              next_state = HOLD;
            end else begin
              imReq       = 1'b1;
              deliver_rsp = 1'b1;
              next_state  = imReady ? WAIT : FETCH;
            end
          end
        end
        KILL: begin
          if (imRValid) next_state = FETCH;
        end
        HOLD: begin
          if (!stall) begin
            deliver_hold = 1'b1;
            next_state   = FETCH;
          end
        end
        default: next_state = FETCH;
      endcase
    end
    if (rst) imReq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      fpc     <= '0;
      h_ins   <= NOP;
      h_pc    <= '0;
      insIF   <= NOP;
      pcIF    <= '0;
      validIF <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) fpc <= imAddr;
      if (hold_load) begin
        h_ins <= imRData;
        h_pc  <= fpc;
      end
      // Decode register: bubble on redirect, hold on stall, otherwise bubble unless fed.
      if (bSel) begin
        validIF <= 1'b0;
      end else if (deliver_rsp) begin
        insIF   <= imRData;
        pcIF    <= fpc;
        validIF <= 1'b1;
      end else if (deliver_hold) begin
        insIF   <= h_ins;
        pcIF    <= h_pc;
        validIF <= 1'b1;
      end else if (!stall) begin
        validIF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, bSel, stall, imReady, imRValid;
  logic [31:0] aluOut, imRData;
  logic        imReq, validIF;
  logic [31:0] imAddr, insIF, pcIF;
  int          nvec = 0;
  int          nerr = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .bSel     (bSel),
    .aluOut   (aluOut),
    .stall    (stall),
    .imReq    (imReq),
    .imAddr   (imAddr),
    .imReady  (imReady),
    .imRValid (imRValid),
    .imRData  (imRData),
    .insIF    (insIF),
    .pcIF     (pcIF),
    .validIF  (validIF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; bSel = 1'b0; stall = 1'b0; imReady = 1'b0;
    imRValid = 1'b0; aluOut = '0; imRData = '0;
    tick(); tick();
    #1;
    chk("rst_ins",   insIF, 32'h0000_0013);
    chk("rst_pc",    pcIF, 32'h0);
    chk("rst_valid", 32'(validIF), 32'h0);
    chk("rst_req",   32'(imReq), 32'h0);

    // 1: zero-wait streaming
    rst = 1'b0; imReady = 1'b1;
    #1;
    chk("t1_req0",  32'(imReq), 32'h1);
    chk("t1_addr0", imAddr, 32'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      imRValid = 1'b1; imRData = 32'(k - 1) * 32'd4 ^ 32'hA5A5_0000;
      #1;
      chk("t1_req",  32'(imReq), 32'h1);
      chk("t1_addr", imAddr, 32'(k) * 32'd4);
      tick();
      chk("t1_pcif",  pcIF, 32'(k - 1) * 32'd4);
      chk("t1_insif", insIF, (32'(k - 1) * 32'd4) ^ 32'hA5A5_0000);
      chk("t1_valid", 32'(validIF), 32'h1);
    end

    // 2: redirect with 0xC outstanding; response 3 cycles later is killed
    imRValid = 1'b0; bSel = 1'b1; aluOut = 32'h0000_0100;
    #1;
    chk("t2_req_bsel", 32'(imReq), 32'h0);
    tick();
    bSel = 1'b0;
    chk("t2_valid0", 32'(validIF), 32'h0);
    chk("t2_state",  32'(dut.state), 32'(KILL));
    #1;
    chk("t2_req_kill", 32'(imReq), 32'h0);
    tick(); tick();
    imRValid = 1'b1; imRData = 32'hDEAD_BEEF;
    #1;
    chk("t2_req_kill2", 32'(imReq), 32'h0);
    tick();
    imRValid = 1'b0;
    chk("t2_stale", 32'(validIF), 32'h0);
    chk("t2_pcif_hold", pcIF, 32'h8);
    #1;
    chk("t2_req_tgt",  32'(imReq), 32'h1);
    chk("t2_addr_tgt", imAddr, 32'h100);
    tick();
    imRValid = 1'b1; imRData = 32'hA5A5_0100;
    #1;
    chk("t2_addr_b2b", imAddr, 32'h104);
    tick();
    chk("t2_pcif",  pcIF, 32'h100);
    chk("t2_valid", 32'(validIF), 32'h1);

    // 3: stall 4 cycles while the 0x104 response arrives
    stall = 1'b1; imRData = 32'hA5A5_0104;
    #1;
    chk("t3_req_s1", 32'(imReq), 32'h0);
    tick();
    imRValid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t3_req_s",  32'(imReq), 32'h0);
      chk("t3_pcif_s", pcIF, 32'h100);
      chk("t3_ins_s",  insIF, 32'hA5A5_0100);
      tick();
    end
    chk("t3_pcif_s4", pcIF, 32'h100);
    stall = 1'b0;
    #1;
    chk("t3_req_rel", 32'(imReq), 32'h0);
    tick();
    chk("t3_pcif_held",  pcIF, 32'h104);
    chk("t3_ins_held",   insIF, 32'hA5A5_0104);
    chk("t3_valid_held", 32'(validIF), 32'h1);
    #1;
    chk("t3_addr_resume", imAddr, 32'h108);

    // 4: stall+redirect together drop the hold buffer
    stall = 1'b1;
    tick();
    imRValid = 1'b1; imRData = 32'hA5A5_0108;
    tick();
    imRValid = 1'b0;
    chk("t4_state_hold", 32'(dut.state), 32'(HOLD));
    chk("t4_valid_pre",  32'(validIF), 32'h1);
    bSel = 1'b1; aluOut = 32'h0000_0200;
    #1;
    chk("t4_req_bsel", 32'(imReq), 32'h0);
    tick();
    bSel = 1'b0; stall = 1'b0;
    chk("t4_valid0", 32'(validIF), 32'h0);
    #1;
    chk("t4_addr_tgt", imAddr, 32'h200);
    tick();
    chk("t4_pcif_nodrop", pcIF, 32'h104);
    imRValid = 1'b1; imRData = 32'hA5A5_0200; imReady = 1'b0;
    tick();
    imRValid = 1'b0;
    chk("t4_pcif_tgt", pcIF, 32'h200);
    chk("t4_valid_tgt", 32'(validIF), 32'h1);

    // 5: memory not ready for 5 cycles in FETCH
    for (int w = 0; w < 5; w++) begin
      #1;
      chk("t5_req",  32'(imReq), 32'h1);
      chk("t5_addr", imAddr, 32'h204);
      tick();
    end
    imReady = 1'b1;
    #1;
    chk("t5_addr_acc", imAddr, 32'h204);
    tick();

    // 6: reset while a response is due
    rst = 1'b1;
    #1;
    chk("t6_req_rst", 32'(imReq), 32'h0);
    tick();
    rst = 1'b0; imRValid = 1'b1; imRData = 32'hBAD0_BAD0;
    chk("t6_valid",  32'(validIF), 32'h0);
    chk("t6_insif",  insIF, 32'h0000_0013);
    #1;
    chk("t6_req",  32'(imReq), 32'h1);
    chk("t6_addr", imAddr, 32'h0);
    tick();
    chk("t6_ignored", 32'(validIF), 32'h0);
    imRData = 32'hA5A5_0000;
    tick();
    chk("t6_pcif",  pcIF, 32'h0);
    chk("t6_insif2", insIF, 32'hA5A5_0000);

    // Redirect to a misaligned top address, then pc wraps to 0
    bSel = 1'b1; aluOut = 32'hFFFF_FFFF; imRData = 32'h1111_1111;
    tick();
    bSel = 1'b0; imRValid = 1'b0;
    chk("w_state", 32'(dut.state), 32'(FETCH));
    chk("w_valid", 32'(validIF), 32'h0);
    #1;
    chk("w_addr", imAddr, 32'hFFFF_FFFC);
    tick();
    imRValid = 1'b1; imRData = 32'h1234_5678;
    #1;
    chk("w_wrap", imAddr, 32'h0);
    tick();
    imRValid = 1'b0;
    chk("w_pcif",  pcIF, 32'hFFFF_FFFC);
    chk("w_insif", insIF, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
